// File: rtl/sensor_alarm_filter_if.sv
// Status/control bundle between the sensor alarm filter and its host.
// The filter side is the slave; the host driving error/clear is the master.
interface sensor_alarm_filter_if #(
  parameter int CNT_W = 8
);
  logic             error_in;
  logic             clear;
  logic             count_clr;
  logic             alarm;
  logic             alarm_pulse;
  logic             pending;
  logic [CNT_W-1:0] event_count;

  modport master (
    output error_in, clear, count_clr,
    input  alarm, alarm_pulse, pending, event_count
  );

  modport slave (
    input  error_in, clear, count_clr,
    output alarm, alarm_pulse, pending, event_count
  );
endinterface

// File: rtl/sensor_alarm_filter.sv
// Debounces a raw sensor error level into a latched alarm with host clear,
// re-arm only after the error drops, and a saturating confirmed-alarm counter.
module sensor_alarm_filter #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sensor_alarm_filter_if.slave  bus
);

  localparam int RUN_W_RAW = $clog2(DEBOUNCE + 1);
  localparam int RUN_W     = (RUN_W_RAW < 1) ? 1 : RUN_W_RAW;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_ALARM  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_next;
  logic             r_alarm_pulse;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_base;
  logic             w_enter_alarm;
  logic             w_alarm;
  logic             w_pending;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    unique case (r_state)
      ST_IDLE: begin
        w_run_next = '0;
        if (bus.error_in) begin
          if (DEBOUNCE == 1) begin
            w_state_next = ST_ALARM;
          end else begin
            w_state_next = ST_FILTER;
            w_run_next   = RUN_ONE;
          end
        end
      end
      ST_FILTER: begin
        if (!bus.error_in) begin
          w_state_next = ST_IDLE;
          w_run_next   = '0;
        end else if (r_run == RUN_LAST) begin
          w_state_next = ST_ALARM;
          w_run_next   = '0;
        end else begin
          w_run_next = r_run + RUN_ONE;
        end
      end
      ST_ALARM: begin
        w_run_next = '0;
        if (bus.clear) begin
          w_state_next = bus.error_in ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_run_next = '0;
        if (!bus.error_in) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_run_next   = '0;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    w_alarm   = (r_state == ST_ALARM);
    w_pending = (r_state == ST_FILTER);
  end

  assign w_enter_alarm = (w_state_next == ST_ALARM) && (r_state != ST_ALARM);
  // A count_clr coinciding with an alarm entry zeroes first, then increments.
  assign w_count_base  = bus.count_clr ? '0 : r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm_pulse <= 1'b0;
      r_count       <= '0;
    end else begin
      r_alarm_pulse <= w_enter_alarm;
      if (w_enter_alarm && (w_count_base != CNT_MAX)) begin
        r_count <= w_count_base + CNT_W'(1);
      end else begin
        r_count <= w_count_base;
      end
    end
  end

  assign bus.alarm       = w_alarm;
  assign bus.pending     = w_pending;
  assign bus.alarm_pulse = r_alarm_pulse;
  assign bus.event_count = r_count;

endmodule

// File: tb/tb_sensor_alarm_filter.sv
// Directed bench: three filter instances (DEBOUNCE=4/CNT_W=8,
// DEBOUNCE=4/CNT_W=2, DEBOUNCE=1/CNT_W=8) sharing clock and reset.
module tb_sensor_alarm_filter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sensor_alarm_filter_if #(.CNT_W(8)) if_a ();
  sensor_alarm_filter_if #(.CNT_W(2)) if_b ();
  sensor_alarm_filter_if #(.CNT_W(8)) if_c ();

  sensor_alarm_filter #(.DEBOUNCE(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  sensor_alarm_filter #(.DEBOUNCE(4), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  sensor_alarm_filter #(.DEBOUNCE(1), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic exp_alarm, input logic exp_pulse,
                         input logic exp_pend, input int exp_cnt);
    checks++;
    if (if_a.alarm !== exp_alarm || if_a.alarm_pulse !== exp_pulse ||
        if_a.pending !== exp_pend || if_a.event_count !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL %s: got alarm=%b pulse=%b pending=%b count=%0d, want alarm=%b pulse=%b pending=%b count=%0d",
               name, if_a.alarm, if_a.alarm_pulse, if_a.pending, if_a.event_count,
               exp_alarm, exp_pulse, exp_pend, exp_cnt);
    end else begin
      $display("ok   %s: alarm=%b pulse=%b pending=%b count=%0d",
               name, if_a.alarm, if_a.alarm_pulse, if_a.pending, if_a.event_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_a("reset", 1'b0, 1'b0, 1'b0, 0);
    checks++;
    if (if_b.event_count !== 2'd0 || if_c.alarm !== 1'b0) begin
      failures++;
      $display("FAIL reset_bc: got b.count=%0d c.alarm=%b, want 0 0", if_b.event_count, if_c.alarm);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_a($sformatf("idle_%0d", i), 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_confirm();
    if_a.error_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_a($sformatf("confirm_edge%0d", i), (i == 4), (i == 4), (i < 4), (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      if_a.error_in = i[0];
      tick();
      check_a($sformatf("alarm_held_%0d", i), 1'b1, 1'b0, 1'b0, 1);
    end
    if_a.clear    = 1'b1;
    if_a.error_in = 1'b0;
    tick();
    check_a("clear_to_idle", 1'b0, 1'b0, 1'b0, 1);
    if_a.clear     = 1'b0;
    if_a.count_clr = 1'b1;
    tick();
    check_a("count_clr_idle", 1'b0, 1'b0, 1'b0, 0);
    if_a.count_clr = 1'b0;
  endtask

  task automatic test_glitch();
    if_a.error_in = 1'b1;
    if_a.clear    = 1'b1;   // clear outside ALARM must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("glitch_run1_%0d", i), 1'b0, 1'b0, 1'b1, 0);
    end
    if_a.clear    = 1'b0;
    if_a.error_in = 1'b0;
    tick();
    check_a("glitch_low", 1'b0, 1'b0, 1'b0, 0);
    if_a.error_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("glitch_run2_%0d", i), 1'b0, 1'b0, 1'b1, 0);
    end
    if_a.error_in = 1'b0;
    tick();
    check_a("glitch_end", 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_hold();
    if_a.error_in = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    check_a("hold_first_alarm", 1'b1, 1'b1, 1'b0, 1);
    if_a.clear = 1'b1;
    tick();
    check_a("hold_enter", 1'b0, 1'b0, 1'b0, 1);
    if_a.clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_a($sformatf("hold_stay_%0d", i), 1'b0, 1'b0, 1'b0, 1);
    end
    if_a.error_in = 1'b0;
    tick();
    check_a("hold_release", 1'b0, 1'b0, 1'b0, 1);
    if_a.error_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_a($sformatf("rearm_edge%0d", i), (i == 4), (i == 4), (i < 4), (i == 4) ? 2 : 1);
    end
    if_a.clear    = 1'b1;
    if_a.error_in = 1'b0;
    tick();
    if_a.clear = 1'b0;
    check_a("hold_done", 1'b0, 1'b0, 1'b0, 2);
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 5; n++) begin
      if_b.error_in = 1'b1;
      for (int i = 1; i <= 4; i++) tick();
      checks++;
      if (if_b.alarm !== 1'b1 || if_b.alarm_pulse !== 1'b1 ||
          if_b.event_count !== 2'((n > 3) ? 3 : n)) begin
        failures++;
        $display("FAIL sat_alarm%0d: got alarm=%b pulse=%b count=%0d, want 1 1 %0d",
                 n, if_b.alarm, if_b.alarm_pulse, if_b.event_count, (n > 3) ? 3 : n);
      end else begin
        $display("ok   sat_alarm%0d: count=%0d", n, if_b.event_count);
      end
      if_b.clear    = 1'b1;
      if_b.error_in = 1'b0;
      tick();
      if_b.clear = 1'b0;
    end
    if_b.error_in = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    if_b.count_clr = 1'b1;
    tick();
    if_b.count_clr = 1'b0;
    checks++;
    if (if_b.alarm !== 1'b1 || if_b.event_count !== 2'd1) begin
      failures++;
      $display("FAIL sat_clr_entry: got alarm=%b count=%0d, want 1 1", if_b.alarm, if_b.event_count);
    end else begin
      $display("ok   sat_clr_entry: count=%0d", if_b.event_count);
    end
    if_b.clear    = 1'b1;
    if_b.error_in = 1'b0;
    tick();
    if_b.clear = 1'b0;
  endtask

  task automatic test_debounce1();
    if_c.error_in = 1'b1;
    tick();
    checks++;
    if (if_c.alarm !== 1'b1 || if_c.alarm_pulse !== 1'b1 || if_c.pending !== 1'b0 ||
        if_c.event_count !== 8'd1) begin
      failures++;
      $display("FAIL d1_alarm: got alarm=%b pulse=%b pending=%b count=%0d, want 1 1 0 1",
               if_c.alarm, if_c.alarm_pulse, if_c.pending, if_c.event_count);
    end else $display("ok   d1_alarm");
    tick();
    checks++;
    if (if_c.alarm !== 1'b1 || if_c.alarm_pulse !== 1'b0) begin
      failures++;
      $display("FAIL d1_pulse_end: got alarm=%b pulse=%b, want 1 0", if_c.alarm, if_c.alarm_pulse);
    end else $display("ok   d1_pulse_end");
    if_c.clear = 1'b1;
    tick();
    if_c.clear = 1'b0;
    tick();
    checks++;
    if (if_c.alarm !== 1'b0 || if_c.event_count !== 8'd1) begin
      failures++;
      $display("FAIL d1_hold: got alarm=%b count=%0d, want 0 1", if_c.alarm, if_c.event_count);
    end else $display("ok   d1_hold");
    if_c.error_in = 1'b0;
    tick();
    if_c.error_in = 1'b1;
    tick();
    checks++;
    if (if_c.alarm !== 1'b1 || if_c.event_count !== 8'd2) begin
      failures++;
      $display("FAIL d1_rearm: got alarm=%b count=%0d, want 1 2", if_c.alarm, if_c.event_count);
    end else $display("ok   d1_rearm");
    if_c.error_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    if_a.error_in = 1'b1;
    tick();
    tick();
    check_a("mid_filter_run2", 1'b0, 1'b0, 1'b1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a("mid_filter_reset", 1'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_a($sformatf("after_rst1_edge%0d", i), (i == 4), (i == 4), (i < 4), (i == 4) ? 1 : 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a("mid_alarm_reset", 1'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_a($sformatf("after_rst2_edge%0d", i), (i == 4), (i == 4), (i < 4), (i == 4) ? 1 : 0);
    end
    if_a.error_in = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    if_a.error_in = 1'b0; if_a.clear = 1'b0; if_a.count_clr = 1'b0;
    if_b.error_in = 1'b0; if_b.clear = 1'b0; if_b.count_clr = 1'b0;
    if_c.error_in = 1'b0; if_c.clear = 1'b0; if_c.count_clr = 1'b0;
    #2;
    test_reset();
    test_confirm();
    test_glitch();
    test_hold();
    test_saturation();
    test_debounce1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

endmodule
